// File: rtl/mem_stage.sv
// Memory stage: issues one data-memory access per load/store, formats load
// results, and stalls the pipeline until the access completes or times out.
module mem_stage #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_result,
    input  logic [31:0] read_data2,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [2:0]  funct3,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] mem_rdata,
    output logic        mem_stall,
    output logic        mem_misalign,
    output logic        mem_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Last counter value that may still see an ack; one more idle BUSY cycle times out.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      state_r;
    state_t      state_next_s;
    logic [7:0]  wait_cnt_r;
    logic [1:0]  addr_lo_r;
    logic [2:0]  funct3_r;
    logic        write_r;

    logic        dmem_req_r;
    logic        dmem_we_r;
    logic [31:0] dmem_addr_r;
    logic [31:0] dmem_wdata_r;
    logic [3:0]  dmem_wstrb_r;
    logic [31:0] mem_rdata_r;
    logic        mem_timeout_r;

    logic        access_s;
    logic        misalign_s;
    logic        start_s;
    logic        ack_s;
    logic        timeout_s;
    logic        mem_stall_s;
    logic        mem_misalign_s;

    // funct3[1:0]: 00 byte, 01 half, 10/11 word.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic result;
        case (f3[1:0])
            2'b00:   result = 1'b0;
            2'b01:   result = lo[0];
            default: result = (lo != 2'b00);
        endcase
        return result;
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] lo);
        logic [3:0] result;
        case (f3[1:0])
            2'b00:   result = 4'b0001 << lo;
            2'b01:   result = 4'b0011 << {lo[1], 1'b0};
            default: result = 4'b1111;
        endcase
        return result;
    endfunction

    // Byte/half data is replicated so every lane carries it; the strobe picks the lane.
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] result;
        case (f3[1:0])
            2'b00:   result = {4{d[7:0]}};
            2'b01:   result = {2{d[15:0]}};
            default: result = d;
        endcase
        return result;
    endfunction

    function automatic logic [31:0] load_format(input logic [2:0] f3, input logic [1:0] lo,
                                                input logic [31:0] word);
        logic [31:0] result;
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = word[{lo[1], 4'b0000} +: 16];
        case (f3[1:0])
            2'b00:   result = f3[2] ? {24'h00_0000, b} : {{24{b[7]}}, b};
            2'b01:   result = f3[2] ? {16'h0000, h} : {{16{h[15]}}, h};
            default: result = word;
        endcase
        return result;
    endfunction

    assign access_s   = memread | memwrite;
    assign misalign_s = is_misaligned(funct3, alu_result[1:0]);
    assign start_s    = (state_r == ST_IDLE) && access_s && !misalign_s;
    assign ack_s      = (state_r == ST_BUSY) && dmem_ack;
    assign timeout_s  = (state_r == ST_BUSY) && !dmem_ack && (wait_cnt_r == WAIT_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: DONE always returns to IDLE after its single cycle.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: state_next_s = start_s ? ST_BUSY : ST_IDLE;
            ST_BUSY: state_next_s = (ack_s || timeout_s) ? ST_DONE : ST_BUSY;
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Combinational stall/misalign so the pipeline freezes in the request cycle itself.
    always_comb begin
        mem_stall_s    = 1'b0;
        mem_misalign_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                mem_stall_s    = access_s && !misalign_s;
                mem_misalign_s = access_s && misalign_s;
            end
            ST_BUSY: mem_stall_s = 1'b1;
            ST_DONE: mem_stall_s = 1'b0;
            default: mem_stall_s = 1'b0;
        endcase
    end

    assign mem_stall    = mem_stall_s;
    assign mem_misalign = mem_misalign_s;

    // Wait counter: cleared on entry to BUSY, counts BUSY cycles without ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_r <= 8'd0;
        end else if (start_s) begin
            wait_cnt_r <= 8'd0;
        end else if ((state_r == ST_BUSY) && !dmem_ack) begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Capture access attributes needed later to format the load result.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_lo_r <= 2'b00;
            funct3_r  <= 3'b000;
            write_r   <= 1'b0;
        end else if (start_s) begin
            addr_lo_r <= alu_result[1:0];
            funct3_r  <= funct3;
            write_r   <= memwrite;
        end else begin
            addr_lo_r <= addr_lo_r;
            funct3_r  <= funct3_r;
            write_r   <= write_r;
        end
    end

    // Registered memory-bus outputs and load result; bus held stable for the whole BUSY phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_req_r    <= 1'b0;
            dmem_we_r     <= 1'b0;
            dmem_addr_r   <= 32'h0000_0000;
            dmem_wdata_r  <= 32'h0000_0000;
            dmem_wstrb_r  <= 4'b0000;
            mem_rdata_r   <= 32'h0000_0000;
            mem_timeout_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    mem_timeout_r <= 1'b0;
                    if (start_s) begin
                        dmem_req_r   <= 1'b1;
                        dmem_we_r    <= memwrite;
                        dmem_addr_r  <= {alu_result[31:2], 2'b00};
                        dmem_wdata_r <= store_data(funct3, read_data2);
                        dmem_wstrb_r <= memwrite ? store_strb(funct3, alu_result[1:0]) : 4'b0000;
                    end
                end
                ST_BUSY: begin
                    if (ack_s) begin
                        dmem_req_r   <= 1'b0;
                        dmem_we_r    <= 1'b0;
                        dmem_wstrb_r <= 4'b0000;
                        if (!write_r) begin
                            mem_rdata_r <= load_format(funct3_r, addr_lo_r, dmem_rdata);
                        end
                    end else if (timeout_s) begin
                        dmem_req_r    <= 1'b0;
                        dmem_we_r     <= 1'b0;
                        dmem_wstrb_r  <= 4'b0000;
                        mem_rdata_r   <= 32'h0000_0000;
                        mem_timeout_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    mem_timeout_r <= 1'b0;
                end
                default: begin
                    dmem_req_r    <= 1'b0;
                    dmem_we_r     <= 1'b0;
                    dmem_wstrb_r  <= 4'b0000;
                    mem_timeout_r <= 1'b0;
                end
            endcase
        end
    end

    assign dmem_req    = dmem_req_r;
    assign dmem_we     = dmem_we_r;
    assign dmem_addr   = dmem_addr_r;
    assign dmem_wdata  = dmem_wdata_r;
    assign dmem_wstrb  = dmem_wstrb_r;
    assign mem_rdata   = mem_rdata_r;
    assign mem_timeout = mem_timeout_r;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table of accesses with a
// scoreboard of expected bus/result values, plus reset corner sequences.
`timescale 1ns/1ps
module tb_mem_stage;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_result;
    logic [31:0] read_data2;
    logic        memread;
    logic        memwrite;
    logic [2:0]  funct3;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] mem_rdata;
    logic        mem_stall;
    logic        mem_misalign;
    logic        mem_timeout;

    always #5 clk = ~clk;

    mem_stage #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_result   (alu_result),
        .read_data2   (read_data2),
        .memread      (memread),
        .memwrite     (memwrite),
        .funct3       (funct3),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_wstrb   (dmem_wstrb),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata),
        .mem_rdata    (mem_rdata),
        .mem_stall    (mem_stall),
        .mem_misalign (mem_misalign),
        .mem_timeout  (mem_timeout)
    );

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_at;     // BUSY-cycle index of ack, -1 = never
        logic        exp_mis;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
        logic        keep_rdata;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        logic        timeout;
        int          busy;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_rdata = 32'h0000_0000;
    exp_t        sb[$];
    vec_t        vecs[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdv,
                                input int ack_at, input logic mis, input logic [31:0] ea,
                                input logic [31:0] ewd, input logic [3:0] ews, input logic keep,
                                input logic [31:0] erd);
        vec_t v;
        v.name = nm; v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wd; v.rdata = rdv;
        v.ack_at = ack_at; v.exp_mis = mis; v.exp_addr = ea; v.exp_wdata = ewd; v.exp_wstrb = ews;
        v.keep_rdata = keep; v.exp_rdata = erd;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   busy;
        bit   done;
        @(negedge clk);
        memread = v.rd; memwrite = v.wr; funct3 = v.f3;
        alu_result = v.addr; read_data2 = v.wdata; dmem_ack = 1'b0;
        #1;
        if (v.exp_mis) begin
            chk({v.name, " misalign"}, 32'(mem_misalign), 32'd1);
            chk({v.name, " stall"}, 32'(mem_stall), 32'd0);
            @(negedge clk);
            memread = 1'b0; memwrite = 1'b0;
            #1;
            chk({v.name, " no_req"}, 32'(dmem_req), 32'd0);
            chk({v.name, " rdata_kept"}, mem_rdata, model_rdata);
            return;
        end
        chk({v.name, " misalign0"}, 32'(mem_misalign), 32'd0);
        chk({v.name, " stall_req_cycle"}, 32'(mem_stall), 32'd1);
        e.name    = v.name;
        e.we      = v.wr;
        e.addr    = v.exp_addr;
        e.wdata   = v.exp_wdata;
        e.wstrb   = v.exp_wstrb;
        e.timeout = (v.ack_at < 0) || (v.ack_at >= MAX_WAIT);
        e.rdata   = e.timeout ? 32'h0000_0000 : (v.keep_rdata ? model_rdata : v.exp_rdata);
        e.busy    = e.timeout ? MAX_WAIT : v.ack_at + 1;
        sb.push_back(e);
        busy = 0;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            memread = 1'b0; memwrite = 1'b0; funct3 = 3'b111;
            alu_result = 32'hFFFF_FFFF; read_data2 = 32'h5555_5555;
            dmem_ack   = (busy == v.ack_at);
            dmem_rdata = (busy == v.ack_at) ? v.rdata : 32'h0BAD_0BAD;
            #1;
            if (dmem_req) begin
                chk({sb[0].name, " busy_stall"}, 32'(mem_stall), 32'd1);
                chk({sb[0].name, " we"}, 32'(dmem_we), 32'(sb[0].we));
                chk({sb[0].name, " addr"}, dmem_addr, sb[0].addr);
                if (sb[0].we) begin
                    chk({sb[0].name, " wdata"}, dmem_wdata, sb[0].wdata);
                    chk({sb[0].name, " wstrb"}, 32'(dmem_wstrb), 32'(sb[0].wstrb));
                end
                busy++;
            end else begin
                dmem_ack = 1'b0;
                done = 1'b1;
            end
        end
        if (!done) begin
            errors++;
            $display("FAIL %s: access never completed within 20 cycles", v.name);
        end
        e = sb.pop_front();
        chk({e.name, " busy_cycles"}, 32'(busy), 32'(e.busy));
        chk({e.name, " done_stall"}, 32'(mem_stall), 32'd0);
        chk({e.name, " timeout"}, 32'(mem_timeout), 32'(e.timeout));
        chk({e.name, " mem_rdata"}, mem_rdata, e.rdata);
        model_rdata = e.rdata;
        @(negedge clk);
        #1;
        chk({e.name, " timeout_cleared"}, 32'(mem_timeout), 32'd0);
        chk({e.name, " idle_stall"}, 32'(mem_stall), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; memread = 1'b0; memwrite = 1'b0; funct3 = 3'b000;
        alu_result = 32'h0; read_data2 = 32'h0; dmem_ack = 1'b0; dmem_rdata = 32'h0;

        //            name     rd    wr    f3      addr          wdata         rdata         ack mis  exp_addr      exp_wdata     wstrb    keep  exp_rdata
        vecs[0]  = mk("LB",    1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_FF7F, 0, 1'b0, 32'h0000_1000, 32'h0,        4'b0000, 1'b0, 32'hFFFF_FF80);
        vecs[1]  = mk("SH",    1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h0,        1, 1'b0, 32'h0000_2000, 32'hABCD_ABCD, 4'b1100, 1'b1, 32'h0);
        vecs[2]  = mk("LWmis", 1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'h0,        32'h0,         0, 1'b1, 32'h0,        32'h0,        4'b0000, 1'b1, 32'h0);
        vecs[3]  = mk("LHUto", 1'b1, 1'b0, 3'b101, 32'h0000_0000, 32'h0,        32'h0,        -1, 1'b0, 32'h0000_0000, 32'h0,        4'b0000, 1'b0, 32'h0);
        vecs[4]  = mk("RWSW",  1'b1, 1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,        2, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 1'b1, 32'h0);
        vecs[5]  = mk("LH",    1'b1, 1'b0, 3'b001, 32'h0000_0002, 32'h0,        32'h8001_1234, 0, 1'b0, 32'h0000_0000, 32'h0,        4'b0000, 1'b0, 32'hFFFF_8001);
        vecs[6]  = mk("LBU",   1'b1, 1'b0, 3'b100, 32'h0000_0001, 32'h0,        32'h0000_F200, 1, 1'b0, 32'h0000_0000, 32'h0,        4'b0000, 1'b0, 32'h0000_00F2);
        vecs[7]  = mk("LHUlast",1'b1,1'b0, 3'b101, 32'h0000_0002, 32'h0,        32'hBEEF_0000, 3, 1'b0, 32'h0000_0000, 32'h0,        4'b0000, 1'b0, 32'h0000_BEEF);
        vecs[8]  = mk("SB",    1'b0, 1'b1, 3'b000, 32'h0000_0003, 32'h0000_00A5, 32'h0,        0, 1'b0, 32'h0000_0000, 32'hA5A5_A5A5, 4'b1000, 1'b1, 32'h0);
        vecs[9]  = mk("LW",    1'b1, 1'b0, 3'b010, 32'h0000_0004, 32'h0,        32'h1234_5678, 0, 1'b0, 32'h0000_0004, 32'h0,        4'b0000, 1'b0, 32'h1234_5678);
        vecs[10] = mk("SHmis", 1'b0, 1'b1, 3'b001, 32'h0000_0001, 32'h1111_2222, 32'h0,        0, 1'b1, 32'h0,        32'h0,        4'b0000, 1'b1, 32'h0);
        vecs[11] = mk("F3mis", 1'b1, 1'b0, 3'b011, 32'h0000_0002, 32'h0,        32'h0,         0, 1'b1, 32'h0,        32'h0,        4'b0000, 1'b1, 32'h0);
        vecs[12] = mk("F3word",1'b1, 1'b0, 3'b011, 32'h0000_0008, 32'h0,        32'hCAFE_F00D, 0, 1'b0, 32'h0000_0008, 32'h0,        4'b0000, 1'b0, 32'hCAFE_F00D);
        vecs[13] = mk("LBpos", 1'b1, 1'b0, 3'b000, 32'h0000_0000, 32'h0,        32'hFFFF_FF7F, 0, 1'b0, 32'h0000_0000, 32'h0,        4'b0000, 1'b0, 32'h0000_007F);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset dmem_req", 32'(dmem_req), 32'd0);
        chk("reset dmem_we", 32'(dmem_we), 32'd0);
        chk("reset dmem_wstrb", 32'(dmem_wstrb), 32'd0);
        chk("reset mem_rdata", mem_rdata, 32'h0);
        chk("reset mem_timeout", 32'(mem_timeout), 32'd0);
        chk("reset mem_stall", 32'(mem_stall), 32'd0);

        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i]);
        end

        // Ack while idle must not touch mem_rdata.
        @(negedge clk);
        dmem_ack = 1'b1; dmem_rdata = 32'h7777_7777;
        @(negedge clk);
        dmem_ack = 1'b0;
        #1;
        chk("idle_ack rdata", mem_rdata, model_rdata);
        chk("idle_ack req", 32'(dmem_req), 32'd0);

        // Reset in the 2nd BUSY cycle, then a late ack one cycle later.
        @(negedge clk);
        memread = 1'b1; funct3 = 3'b010; alu_result = 32'h0000_0040;
        #1;
        chk("rstbusy stall", 32'(mem_stall), 32'd1);
        @(negedge clk);
        memread = 1'b0;
        #1;
        chk("rstbusy busy1 req", 32'(dmem_req), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstbusy busy2 req", 32'(dmem_req), 32'd1);
        @(negedge clk);
        rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("rstbusy req_dropped", 32'(dmem_req), 32'd0);
        chk("rstbusy stall", 32'(mem_stall), 32'd0);
        chk("rstbusy no_done_timeout", 32'(mem_timeout), 32'd0);
        chk("rstbusy rdata", mem_rdata, 32'h0);
        @(negedge clk);
        dmem_ack = 1'b0;
        #1;
        chk("late_ack req", 32'(dmem_req), 32'd0);
        chk("late_ack rdata", mem_rdata, 32'h0);
        chk("late_ack timeout", 32'(mem_timeout), 32'd0);
        model_rdata = 32'h0;

        // Back in IDLE: a normal access must work again.
        run_vec(vecs[0]);
        chk("scoreboard empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15, giving the maximum number of BUSY cycles waited for dmem_ack before timeout (legal range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port alu_result, input, 32 bits: byte address from the execution stage.
REQ-005 SHALL have port read_data2, input, 32 bits: store data (rs2).
REQ-006 SHALL have ports memread and memwrite, input, 1 bit each: load and store request from control.
REQ-007 SHALL have port funct3, input, 3 bits: access size and signedness.
REQ-008 SHALL have port dmem_req, output, 1 bit: data-memory request.
REQ-009 SHALL have port dmem_we, output, 1 bit: write enable.
REQ-010 SHALL have port dmem_addr, output, 32 bits: word-aligned address.
REQ-011 SHALL have port dmem_wdata, output, 32 bits: lane-positioned write data.
REQ-012 SHALL have port dmem_wstrb, output, 4 bits: byte enables.
REQ-013 SHALL have port dmem_ack, input, 1 bit: one-cycle completion pulse.
REQ-014 SHALL have port dmem_rdata, input, 32 bits: read word, valid with dmem_ack.
REQ-015 SHALL have port mem_rdata, output, 32 bits: formatted load result.
REQ-016 SHALL have port mem_stall, output, 1 bit: holds PC and pipeline while high.
REQ-017 SHALL have port mem_misalign, output, 1 bit: misaligned access detected.
REQ-018 SHALL have port mem_timeout, output, 1 bit: access abandoned after MAX_WAIT cycles.

Function
REQ-019 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-020 In IDLE, an aligned access (memread|memwrite) SHALL assert mem_stall combinationally, capture address/data/funct3/write, and move to BUSY.
REQ-021 If memread and memwrite are both high, the access SHALL be treated as a write.
REQ-022 Alignment: halfword requires addr[0]=0; word requires addr[1:0]=0; funct3[1:0]=11 SHALL be treated as word.
REQ-023 A misaligned access in IDLE SHALL assert mem_misalign combinationally, keep mem_stall=0, issue no dmem_req, and stay in IDLE.
REQ-024 In BUSY, dmem_req SHALL be 1 and dmem_we/addr/wdata/wstrb SHALL be driven from the captured values, held stable until dmem_ack.
REQ-025 Stores SHALL use wstrb SB=0001<<addr[1:0], SH=0011<<{addr[1],1'b0}, SW=1111, with byte/half replicated across all lanes of wdata.
REQ-026 Loads SHALL select the lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through; the result SHALL be registered into mem_rdata on dmem_ack.
REQ-027 On dmem_ack in BUSY, the FSM SHALL move to DONE; a store SHALL leave mem_rdata unchanged.
REQ-028 A wait counter SHALL clear on entry to BUSY and increment each BUSY cycle without ack; at count==MAX_WAIT it SHALL go to DONE, set mem_timeout=1, set mem_rdata=0, and drop dmem_req.
REQ-029 In DONE, mem_stall SHALL be 0 for exactly one cycle, and the next state SHALL be IDLE unconditionally.
REQ-030 mem_timeout SHALL be asserted only in DONE.
REQ-031 dmem_ack outside BUSY SHALL be ignored.
REQ-032 Minimum access latency SHALL be 3 cycles (IDLE, BUSY with ack, DONE).
REQ-033 With no access requested, mem_stall SHALL be 0 and dmem_req SHALL be 0.

Reset
REQ-034 rst SHALL force state IDLE, counter 0, mem_rdata 0, mem_timeout 0, and dmem_req/dmem_we/dmem_wstrb 0 on the next edge.
REQ-035 rst asserted while in BUSY SHALL drop dmem_req the following cycle without entering DONE, and any late ack SHALL be ignored.

Verification
REQ-036 LB at 0x1003 with rdata=0x80FF_FF7F and ack in the 1st BUSY cycle -> dmem_addr=0x1000, mem_rdata=0xFFFF_FF80, mem_stall high for 2 cycles.
REQ-037 SH at 0x2002 with read_data2=0x1234_ABCD -> dmem_wstrb=1100, dmem_wdata=0xABCD_ABCD, dmem_we=1.
REQ-038 LW at 0x3001 -> mem_misalign=1, mem_stall=0, dmem_req stays 0.
REQ-039 LHU at 0x0 with no ack and MAX_WAIT=4 -> 4 BUSY cycles, then DONE with mem_timeout=1 and mem_rdata=0.
REQ-040 rst in the 2nd BUSY cycle followed by ack one cycle later -> dmem_req=0, state IDLE, mem_rdata=0.
REQ-041 memread=memwrite=1 with SW at 0x10 -> write issued with dmem_wstrb=1111 and mem_rdata unchanged.
